mem_handshake_ctrl: RTL

Parametrised multi-channel controller between the CPU datapath and the asynchronous-style memory handshake (`readM`/`writeM`/`address`/`data`, `inputReady`/`ackOutput`). It accepts read/write requests from up to `NUM_CH` clients, such as instruction fetch and data access, and arbitrates them round-robin. It runs one memory transaction at a time, with a timeout and a recovery phase, and returns read data or a write completion to the requesting channel. This replaces the ad-hoc handshake sequencing inside the multi-cycle CPU.

---
 rtl/mem_handshake_ctrl_pkg.sv | 13 +
 rtl/mem_handshake_ctrl_rr_arbiter.sv | 33 +++
 rtl/mem_handshake_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared definitions for the memory handshake controller and its arbiter.
package mem_handshake_ctrl_pkg;

  localparam int DEF_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/mem_handshake_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx
);

  localparam int unsigned N = NUM_CH;

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Multi-channel round-robin controller for the readM/writeM memory handshake,
// with per-transaction timeout and a recovery phase that waits out stale responses.
module mem_handshake_ctrl
  import mem_handshake_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT   = 255,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH-1:0]             req_write,
  input  logic [NUM_CH*ADDR_W-1:0]      req_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0]   req_wdata,
  output logic [NUM_CH-1:0]             req_ready,
  output logic                          resp_valid,
  output logic [CW-1:0]                 resp_ch,
  output logic [WORD_SIZE-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic                          readM,
  output logic                          writeM,
  output logic [ADDR_W-1:0]             address,
  inout  logic [WORD_SIZE-1:0]          data,
  input  logic                          inputReady,
  input  logic                          ackOutput
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

  state_t               state;
  logic [CW-1:0]        rr_ptr;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [TW-1:0]        tcnt;

  logic [NUM_CH-1:0]    grant;
  logic [CW-1:0]        gidx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                 sel_write;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
        sel_write = req_write[i];
      end
    end
  end

  assign data = writeM ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      wdata_q    <= '0;
      tcnt       <= '0;
      req_ready  <= '0;
      resp_valid <= 1'b0;
      resp_ch    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      readM      <= 1'b0;
      writeM     <= 1'b0;
      address    <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ready <= grant;
            address   <= sel_addr;
            wdata_q   <= sel_wdata;
            resp_ch   <= gidx;
            tcnt      <= '0;
            readM     <= !sel_write;
            writeM    <= sel_write;
            state     <= sel_write ? ST_WRITE : ST_READ;
            rr_ptr    <= (gidx == LAST_CH) ? '0 : gidx + 1'b1;
          end
        end
        ST_READ: begin
          if (inputReady) begin
            readM      <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= data;
            state      <= ST_RECOVER;
          end else if (tcnt == TLAST) begin
            readM      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= ST_RECOVER;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_WRITE: begin
          if (ackOutput) begin
            writeM     <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RECOVER;
          end else if (tcnt == TLAST) begin
            writeM     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= ST_RECOVER;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          // Hold off until the memory has released both handshake lines.
          if (!inputReady && !ackOutput) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
